mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst input 1, active-low asynchronous reset.
REQ-002 Upstream (EX/MEM) ports SHALL be:
- validIn input 1: operation present.
- memReadIn input 1: load.
- memWriteIn input 1: store.
- sizeIn input 2: access size, 00 byte, 01 half, 10 word, 11 treated as word.
- signedIn input 1: sign-extend loads.
- controlIn input 2: writeback control.
- addrIn input 32: effective address, equal to the ALU result.
- storeDataIn input 32: store data.
- destRegIn input 5: destination register.
REQ-003 Memory bus ports SHALL be:
- memReq output 1: request.
- memWe output 1: write.
- memAddr output 32: word address.
- memWdata output 32: write data.
- memBe output 4: byte enables.
- memAck input 1: completion.
- memRdata input 32: read word.
REQ-004 Downstream (MEM/WB) and hazard ports SHALL be:
- controlOut output 2.
- memDataOut output 32.
- aluResultOut output 32.
- destRegOut output 5.
- stall output 1: freeze upstream stages.
- misalignedOut output 1: misaligned access flag.

Function
REQ-005 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-006 In IDLE with validIn=1 and (memReadIn or memWriteIn), the FSM SHALL move to BUSY on the next edge.
REQ-007 In BUSY with memAck=1, the FSM SHALL move to DONE; otherwise it SHALL stay in BUSY indefinitely.
REQ-008 The FSM SHALL leave DONE for IDLE unconditionally after one cycle.
REQ-009 memReq SHALL be 1 only in BUSY, and memWe SHALL equal the latched write flag in BUSY and be 0 otherwise.
REQ-010 On the IDLE->BUSY edge the block SHALL latch memAddr = {addrIn[31:2],2'b00}, memBe, memWdata, size, signed and the write flag, and SHALL hold them constant through BUSY.
REQ-011 memBe SHALL be 0001<<addr[1:0] for byte, 0011 for half with addr[1]=0, 1100 for half with addr[1]=1, and 1111 for word.
REQ-012 memWdata SHALL be the byte replicated 4x for byte stores, the halfword replicated 2x for half stores, and the unmodified data for word stores.
REQ-013 On memAck in BUSY, a load SHALL capture the selected lane of memRdata, sign-extended when signed=1 and zero-extended otherwise, into the data register.
REQ-014 On memAck in BUSY, a store SHALL write 0 into the data register.
REQ-015 stall SHALL be 1 in IDLE when a memory operation is presented, and SHALL be 1 in BUSY; it SHALL be 0 in DONE and for non-memory operations.
- Upstream holds all inputs stable while stall=1.
REQ-016 controlOut, aluResultOut and destRegOut SHALL pass controlIn, addrIn and destRegIn through combinationally.
REQ-017 controlOut SHALL be forced to 0 whenever stall=1 or validIn=0, so that a bubble is inserted into MEM/WB.
REQ-018 memDataOut SHALL equal the data register in DONE and 0 otherwise.
REQ-019 Minimum memory-operation latency SHALL be 3 cycles (IDLE, BUSY with immediate ack, DONE); each extra BUSY cycle adds one cycle.
REQ-020 Non-memory operations SHALL complete in 0 added cycles.
REQ-021 memAck outside BUSY SHALL be ignored.
REQ-022 If memReadIn and memWriteIn are both 1, the operation SHALL be executed as a store.

Reset
REQ-023 While rst=0, the block SHALL set the FSM to IDLE and clear every latched address, enable, data and flag register.
REQ-024 During reset, memReq, memWe, stall, misalignedOut and memDataOut SHALL be 0.
REQ-025 Reset asserted during BUSY SHALL abandon the transaction, with memReq dropping asynchronously and no data captured.

Configuration
REQ-026 With MEM_ALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no request and raise no stall.
- In that case misalignedOut=1 for the cycle the operation is presented, controlOut=0 and the FSM stays in IDLE.
REQ-027 With MEM_ALIGN_CHECK_EN undefined, misalignedOut SHALL be tied to 0.
- addr[0] is ignored for half accesses and addr[1:0] for word accesses, so accesses proceed as if aligned.

Verification
REQ-028 Word load, addr 0x00000104, memAck in the first BUSY cycle, memRdata 0xDEADBEEF -> memAddr 0x104, memBe 1111, stall high for 2 cycles, memDataOut 0xDEADBEEF in DONE.
REQ-029 Signed byte load, addr 0x203, memRdata 0x80112233 -> memBe 1000, memDataOut 0xFFFFFF80; the unsigned variant -> 0x00000080.
REQ-030 Half store, addr 0x12, data 0x0000ABCD, memAck delayed 4 cycles -> memBe 1100, memWdata 0xABCDABCD, memWe=1, stall held for 5 cycles, controlOut=0 while stalled.
REQ-031 ALU operation, memReadIn=0, memWriteIn=0, controlIn=2'b10 -> stall=0, memReq never 1, controlOut=2'b10, memDataOut=0.
REQ-032 Reset pulled low in the second BUSY cycle of a load -> memReq=0 immediately, FSM in IDLE, memDataOut=0, no capture when a late memAck arrives.
REQ-033 With MEM_ALIGN_CHECK_EN defined, word load at addr 0x102 -> misalignedOut=1, memReq=0, stall=0, controlOut=0; with the macro undefined -> access at memAddr 0x100, memBe 1111.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a req/ack memory bus through an IDLE/BUSY/DONE FSM.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of force-aligning them.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        validIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [1:0]  sizeIn,
    input  logic        signedIn,
    input  logic [1:0]  controlIn,
    input  logic [31:0] addrIn,
    input  logic [31:0] storeDataIn,
    input  logic [4:0]  destRegIn,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic [1:0]  controlOut,
    output logic [31:0] memDataOut,
    output logic [31:0] aluResultOut,
    output logic [4:0]  destRegOut,
    output logic        stall,
    output logic        misalignedOut
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [1:0] sizeQ, offQ;
    logic signedQ, weQ;
    logic [31:0] dataQ;
    logic memOp, misaligned, start;
    logic [3:0] beNext;
    logic [31:0] wdataNext, loadVal;
    logic [7:0] ldByte;
    logic [15:0] ldHalf;
    always_comb begin
        memOp = validIn & (memReadIn | memWriteIn);
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = memOp & ((sizeIn == 2'b01) ? addrIn[0] : (sizeIn[1] & (addrIn[1:0] != 2'b00)));
`else
        misaligned = 1'b0;
`endif
        start = (state == IDLE) & memOp & ~misaligned;
        beNext = (sizeIn == 2'b00) ? (4'b0001 << addrIn[1:0]) :
                 (sizeIn == 2'b01) ? (addrIn[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdataNext = (sizeIn == 2'b00) ? {4{storeDataIn[7:0]}} :
                    (sizeIn == 2'b01) ? {2{storeDataIn[15:0]}} : storeDataIn;
        ldByte = memRdata[{offQ, 3'b000} +: 8];
        ldHalf = offQ[1] ? memRdata[31:16] : memRdata[15:0];
        loadVal = (sizeQ == 2'b00) ? {{24{signedQ & ldByte[7]}}, ldByte} :
                  (sizeQ == 2'b01) ? {{16{signedQ & ldHalf[15]}}, ldHalf} : memRdata;
    end
    // Bus strobes decode straight from state so an async reset drops them immediately.
    assign memReq        = (state == BUSY);
    assign memWe         = memReq & weQ;
    assign stall         = rst & (start | (state == BUSY));
    assign misalignedOut = rst & (state == IDLE) & misaligned;
    assign controlOut    = (stall | ~validIn | misalignedOut) ? 2'b00 : controlIn;
    assign memDataOut    = (state == DONE) ? dataQ : 32'h0;
    assign aluResultOut  = addrIn;
    assign destRegOut    = destRegIn;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            memAddr  <= 32'h0;
            memBe    <= 4'h0;
            memWdata <= 32'h0;
            sizeQ    <= 2'b00;
            offQ     <= 2'b00;
            signedQ  <= 1'b0;
            weQ      <= 1'b0;
            dataQ    <= 32'h0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= BUSY;
                    memAddr  <= {addrIn[31:2], 2'b00};
                    memBe    <= beNext;
                    memWdata <= wdataNext;
                    sizeQ    <= sizeIn;
                    offQ     <= addrIn[1:0];
                    signedQ  <= signedIn;
                    weQ      <= memWriteIn;
                end
                BUSY: if (memAck) begin
                    state <= DONE;
                    dataQ <= weQ ? 32'h0 : loadVal;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
